// File: rtl/present_pkg.sv
// Shared PRESENT constants, state encoding and combinational round helpers.
// Key size follows PRESENT_KEY128_EN (defined: 128-bit key, undefined: 80-bit key).
package present_pkg;

    localparam int BLOCK_W    = 64;
`ifdef PRESENT_KEY128_EN
    localparam int KEY_W      = 128;
    localparam int KEY_SBOXES = 2;
`else
    localparam int KEY_W      = 80;
    localparam int KEY_SBOXES = 1;
`endif
    localparam int NUM_ROUNDS = 31;

    // Nibble n holds S(n): 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2
    localparam logic [63:0] SBOX_TABLE = 64'h21748FE3DA09B65C;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < 63; i++) begin
            p[(16 * i) % 63] = s[i];
        end
        p[63] = s[63];
        return p;
    endfunction

    function automatic logic [KEY_W-1:0] key_rotate(input logic [KEY_W-1:0] k);
        return {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
    endfunction

    // sb carries the S-box output(s) for the top nibble(s) of the rotated key.
    function automatic logic [KEY_W-1:0] key_finish(input logic [KEY_W-1:0]      rot,
                                                     input logic [4*KEY_SBOXES-1:0] sb,
                                                     input logic [4:0]             r);
        logic [KEY_W-1:0] k;
        k = rot;
        k[KEY_W-1 -: 4*KEY_SBOXES] = sb;
`ifdef PRESENT_KEY128_EN
        k[66:62] = k[66:62] ^ r;
`else
        k[19:15] = k[19:15] ^ r;
`endif
        return k;
    endfunction

endpackage

// File: rtl/present_encrypt_sbox.sv
// Forward PRESENT S-box, one nibble, purely combinational.
module sbox_encrypt
    import present_pkg::*;
(
    input  logic [3:0] value,
    output logic [3:0] subst
);

    assign subst = SBOX_TABLE[{value, 2'b00} +: 4];

endmodule

// File: rtl/present_encrypt.sv
// Iterative PRESENT encryption core: one round per cycle, valid/ready in and out.
// Key size selected by macro PRESENT_KEY128_EN (80-bit when undefined).
module present_encrypt
    import present_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] plaintext,
    input  logic [KEY_W-1:0]   key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] ciphertext
);

    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

    state_t              state;
    logic [BLOCK_W-1:0]  state_reg;
    logic [KEY_W-1:0]    key_reg;
    logic [4:0]          round;

    logic [BLOCK_W-1:0]  round_key;
    logic [BLOCK_W-1:0]  mixed;
    logic [BLOCK_W-1:0]  sliced;
    logic [BLOCK_W-1:0]  next_state;
    logic [KEY_W-1:0]    rotated;
    logic [KEY_W-1:0]    next_key;
    logic [4*KEY_SBOXES-1:0] key_sb;

    assign round_key = key_reg[KEY_W-1 -: BLOCK_W];
    assign mixed     = state_reg ^ round_key;

    for (genvar g = 0; g < 16; g++) begin : g_slayer
        sbox_encrypt u_sbox (
            .value (mixed[4*g +: 4]),
            .subst (sliced[4*g +: 4])
        );
    end

    assign next_state = p_layer(sliced);
    assign rotated    = key_rotate(key_reg);

    for (genvar j = 0; j < KEY_SBOXES; j++) begin : g_ksbox
        sbox_encrypt u_sbox (
            .value (rotated[KEY_W - 4*KEY_SBOXES + 4*j +: 4]),
            .subst (key_sb[4*j +: 4])
        );
    end

    assign next_key = key_finish(rotated, key_sb, round);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            ciphertext <= '0;
            state_reg  <= '0;
            key_reg    <= '0;
            round      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_reg <= plaintext;
                        key_reg   <= key;
                        round     <= 5'd1;
                        in_ready  <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    state_reg <= next_state;
                    key_reg   <= next_key;
                    // Final addRoundKey with K32 is folded into the last round edge.
                    if (round == LAST_ROUND) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        ciphertext <= next_state ^ next_key[KEY_W-1 -: BLOCK_W];
                    end else begin
                        round <= round + 5'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state      <= IDLE;
                        out_valid  <= 1'b0;
                        ciphertext <= '0;
                        in_ready   <= 1'b1;
                        round      <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_present_encrypt.sv
// Self-checking bench for present_encrypt: known vectors, random vs. reference model,
// backpressure and mid-run reset. Honours PRESENT_KEY128_EN like the RTL.
module tb_present_encrypt;
    import present_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [63:0]        plaintext;
    logic [KEY_W-1:0]   key;
    logic               out_valid;
    logic               out_ready;
    logic [63:0]        ciphertext;

    int pass_count = 0;
    int total_count = 0;

    present_encrypt dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]  pt;
        logic [127:0] k;
        logic [63:0]  exp;
    } vec_t;

    vec_t vecs[$];

    int sb_tab[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    // Reference: straight from the cipher description, bit by bit.
    function automatic logic [63:0] ref_present(input logic [63:0] pt, input logic [127:0] k_in);
        logic [KEY_W-1:0] k;
        logic [63:0]      s;
        logic [63:0]      t;
        k = k_in[KEY_W-1:0];
        s = pt;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[KEY_W-1 -: 64];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = 4'(sb_tab[s[4*n +: 4]]);
            t = '0;
            for (int i = 0; i < 63; i++) t[(16 * i) % 63] = s[i];
            t[63] = s[63];
            s = t;
            k = (k << 61) | (k >> (KEY_W - 61));
            k[KEY_W-1 -: 4] = 4'(sb_tab[k[KEY_W-1 -: 4]]);
`ifdef PRESENT_KEY128_EN
            k[KEY_W-5 -: 4] = 4'(sb_tab[k[KEY_W-5 -: 4]]);
            k[66:62] = k[66:62] ^ 5'(r);
`else
            k[19:15] = k[19:15] ^ 5'(r);
`endif
        end
        return s ^ k[KEY_W-1 -: 64];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_count++;
        if (act === exp) pass_count++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic scramble_inputs();
        in_valid  = 1'($urandom);
        plaintext = {$urandom, $urandom};
        key       = KEY_W'({$urandom, $urandom, $urandom, $urandom});
    endtask

    // Accept a block, wait for out_valid (bounded), return ciphertext and latency.
    task automatic run_block(input logic [63:0] pt, input logic [127:0] k, input bit toggle,
                             output logic [63:0] ct, output int lat);
        plaintext = pt;
        key       = k[KEY_W-1:0];
        in_valid  = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        if (toggle) scramble_inputs(); else in_valid = 1'b0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (toggle) scramble_inputs();
        end
        in_valid = 1'b0;
        ct = ciphertext;
    endtask

    task automatic complete();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0]  ct;
        logic [63:0]  pt;
        logic [127:0] k;
        logic [63:0]  held;
        int           lat;
        bit           seen;

`ifdef PRESENT_KEY128_EN
        vecs.push_back('{64'h0, 128'h0, 64'h96DB702A2E6900AF});
`else
        vecs.push_back('{64'h0, 128'h0, 64'h5579C1387B228445});
        vecs.push_back('{64'h0, {128{1'b1}}, 64'hE72C46C0F5945049});
        vecs.push_back('{{64{1'b1}}, 128'h0, 64'hA112FFC72F68417B});
        vecs.push_back('{{64{1'b1}}, {128{1'b1}}, 64'h3333DCD3213210D2});
`endif

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; key = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_ciphertext", ciphertext, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_block(vecs[i].pt, vecs[i].k, 1'b0, ct, lat);
            check($sformatf("vec%0d_ct", i), ct, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
            complete();
        end

        // Random blocks; odd iterations also scramble inputs throughout the run.
        for (int i = 0; i < 8; i++) begin
            pt = {$urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            run_block(pt, k, (i % 2) == 1, ct, lat);
            check($sformatf("rand%0d_ct", i), ct, ref_present(pt, k));
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'd32);
            complete();
        end

        // Backpressure: output held for 10 cycles with out_ready low.
        pt = {$urandom, $urandom};
        k  = {$urandom, $urandom, $urandom, $urandom};
        run_block(pt, k, 1'b0, ct, lat);
        held = ref_present(pt, k);
        check("bp_first_ct", ct, held);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_ct", c), ciphertext, held);
            check($sformatf("bp_hold%0d_in_ready", c), 64'(in_ready), 64'd0);
            check($sformatf("bp_hold%0d_out_valid", c), 64'(out_valid), 64'd1);
        end
        complete();
        check("bp_after_in_ready", 64'(in_ready), 64'd1);
        check("bp_after_out_valid", 64'(out_valid), 64'd0);
        check("bp_after_ct", ciphertext, 64'd0);

        // Reset while round 15 is in progress.
        plaintext = {$urandom, $urandom};
        key       = KEY_W'({$urandom, $urandom, $urandom, $urandom});
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_ct", ciphertext, 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_output", 64'(seen), 64'd0);
        run_block(vecs[0].pt, vecs[0].k, 1'b0, ct, lat);
        check("post_abort_ct", ct, vecs[0].exp);
        check("post_abort_latency", 64'(lat), 64'd32);
        complete();

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule

// File: doc/present_encrypt.md
PRESENT_ENCRYPT -- requirements
Module: present_encrypt

Interface
REQ-001 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1, plaintext/key offer valid.
REQ-004 SHALL have port in_ready, output, 1, core can accept a block.
REQ-005 SHALL have port plaintext, input, 64, block to encrypt.
REQ-006 SHALL have port key, input, KEY_W (80 by default), cipher key sampled at accept.
REQ-007 SHALL have port out_valid, output, 1, ciphertext available.
REQ-008 SHALL have port out_ready, input, 1, consumer accepts ciphertext.
REQ-009 SHALL have port ciphertext, output, 64, encrypted block.

Function
REQ-010 SHALL implement PRESENT encryption: 31 rounds of addRoundKey, sLayer and pLayer, then a final addRoundKey with K32.
REQ-011 SHALL use forward S-box 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2, applied to all 16 nibbles in parallel.
REQ-012 pLayer SHALL move bit i to bit (16*i) mod 63 for i in 0..62; bit 63 stays at bit 63.
REQ-013 Round key SHALL be key_reg[KEY_W-1 -: 64].
REQ-014 80-bit key update after round r SHALL be: rotate left 61; S-box on [79:76]; XOR r[4:0] into [19:15].
REQ-015 FSM SHALL have states IDLE, RUN and DONE.
- IDLE: in_ready=1.
- RUN: one round per cycle.
- DONE: out_valid=1.
REQ-016 In IDLE, in_valid&&in_ready SHALL load state_reg=plaintext, key_reg=key and round=1, then go to RUN.
REQ-017 In RUN, each cycle SHALL perform round `round` and increment `round`; after round 31 it SHALL go to DONE.
REQ-018 Latency SHALL be exactly 32 cycles from the accept edge to the first cycle with out_valid high.
REQ-019 In DONE, ciphertext SHALL be state_reg XOR round key; ciphertext SHALL be 0 whenever out_valid is 0.
REQ-020 out_valid and ciphertext SHALL hold stable until out_ready is sampled high; on that edge the FSM SHALL go to IDLE.
REQ-021 in_ready SHALL be 0 in RUN and DONE; no accept may occur in the same cycle as an out_ready completion.
REQ-022 in_valid and plaintext/key changes SHALL be ignored outside IDLE; ciphertext SHALL depend only on the values captured at accept.
REQ-023 The round counter SHALL be 5 bits and SHALL never wrap during an operation.

Reset
REQ-024 rst SHALL force the FSM to IDLE, and in_ready=1, out_valid=0, ciphertext=0, state_reg=0, key_reg=0, round=0.
REQ-025 rst asserted in RUN or DONE SHALL abort and discard the operation with no ciphertext emitted; rst SHALL take priority over all handshakes.

Configuration
REQ-026 Macro PRESENT_KEY128_EN SHALL select the key size.
- Defined: KEY_W=128; key update is rotate left 61, S-box on [127:124] and [123:120], XOR r into [66:62].
- Undefined: KEY_W=80 per REQ-014.
- Latency and handshake SHALL be identical in both builds.

Structure
REQ-027 Shared package present_pkg SHALL hold BLOCK_W=64, KEY_W (macro-dependent), NUM_ROUNDS=31, the forward S-box table and the FSM state enum typedef.
REQ-028 A sub-module sbox_encrypt (4-bit in, 4-bit out, combinational) SHALL be instantiated 16 times for the sLayer, and additionally once (80-bit) or twice (128-bit) for the key schedule.
REQ-029 pLayer and the key update SHALL be combinational functions in present_pkg.

Verification
REQ-030 80-bit build: plaintext=0, key=0 -> ciphertext 5579C1387B228445, out_valid exactly 32 cycles after accept.
REQ-031 80-bit build, three vectors:
- pt=0, key=all-F -> E72C46C0F5945049
- pt=all-F, key=0 -> A112FFC72F68417B
- pt=all-F, key=all-F -> 3333DCD3213210D2
REQ-032 Backpressure: hold out_ready=0 for 10 cycles after out_valid. Ciphertext SHALL stay stable and in_ready=0. After out_ready=1 for one cycle, in_ready=1 on the next cycle.
REQ-033 Toggle in_valid, plaintext and key every cycle during RUN -> ciphertext still matches the values captured at accept.
REQ-034 Assert rst at round 15 -> next cycle: IDLE, out_valid=0, ciphertext=0. A fresh pt=0/key=0 run then SHALL yield 5579C1387B228445.
REQ-035 PRESENT_KEY128_EN build: pt=0, key=0 -> ciphertext 96DB702A2E6900AF with 32-cycle latency.
